// File: rtl/pipe_store_buffer_pkg.sv
// Shared constants, word-address slice macro and store-entry layout for the
// posted-write store buffer and its forwarding matcher.
`ifndef SB_WORD_SLICE
`define SB_WORD_SLICE(aw) [(aw)-1:2]
`endif

package pipe_store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   // One buffered store: word address (byte offset dropped) above the data.
   typedef struct packed {
      logic [SB_AW-3:0] waddr;
      logic [SB_DW-1:0] wdata;
   } sb_entry_t;

   function automatic int sb_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Combinational store-to-load forwarding match: the youngest valid entry
// whose word address equals the load word address supplies the data.
module sb_fwd_match
   import pipe_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW,
   localparam int PW   = sb_ptr_w(DEPTH),
   localparam int EW   = AW - 2 + DW
) (
   input  logic [DEPTH-1:0][EW-1:0] i_ent,
   input  logic [DEPTH-1:0]         i_valid,
   input  logic [PW-1:0]            i_head,
   input  logic [AW-3:0]            i_ld_waddr,
   output logic                     o_hit,
   output logic [DW-1:0]            o_hit_data
);

   logic [PW-1:0] w_idx;

   // Walk oldest to youngest from head; a later match overrides an earlier one.
   always_comb begin
      o_hit      = 1'b0;
      o_hit_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PW'(k);
         if (i_valid[w_idx] && (i_ent[w_idx][EW-1:DW] == i_ld_waddr)) begin
            o_hit      = 1'b1;
            o_hit_data = i_ent[w_idx][DW-1:0];
         end
      end
   end

endmodule

// File: rtl/pipe_store_buffer.sv
// Posted-write store buffer between the MEM stage and data memory: stores
// enqueue in one cycle, drain over valid/ready, and forward to later loads.
module pipe_store_buffer
   import pipe_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   output logic [DW-1:0] ld_data,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_wvalid,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_wready,
   output logic          full,
   output logic          empty,
   output logic          overflow
);

   localparam int PW = sb_ptr_w(DEPTH);
   localparam int EW = AW - 2 + DW;
   localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

   logic [DEPTH-1:0][EW-1:0] r_ent;
   logic [PW-1:0]            r_head;
   logic [PW-1:0]            r_tail;
   logic [PW:0]              r_count;
   logic                     r_overflow;

   logic                     w_full;
   logic                     w_deq;
   logic                     w_enq;
   logic [DEPTH-1:0]         w_valid;
   logic                     w_hit;
   logic [DW-1:0]            w_hit_data;
   logic                     w_unused_st_lsbs;

   assign w_full = (r_count == CNT_FULL);
   assign w_deq  = mem_wvalid && mem_wready;
   // A full buffer still accepts a store when the head drains on the same edge.
   assign w_enq  = st_valid && (!w_full || w_deq);

   // NOTE: reset is synchronous, so it lives inside the clocked block and
   // every state update there is non-blocking.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_enq) r_tail <= r_tail + PW'(1);
         if (w_deq) r_head <= r_head + PW'(1);
         r_count <= r_count + {{PW{1'b0}}, w_enq} - {{PW{1'b0}}, w_deq};
         if (st_valid && w_full && !w_deq) r_overflow <= 1'b1;
      end
   end

   // NOTE: entry storage is not reset; an entry is only ever read while
   // r_count marks it valid, so its power-up contents never escape.
   always_ff @(posedge clock) begin
      if (w_enq) r_ent[r_tail] <= {st_addr `SB_WORD_SLICE(AW), st_data};
   end

   always_comb begin
      w_valid = '0;
      for (int i = 0; i < DEPTH; i++)
         w_valid[i] = ({1'b0, PW'(i) - r_head} < r_count);
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd (
      .i_ent      (r_ent),
      .i_valid    (w_valid),
      .i_head     (r_head),
      .i_ld_waddr (ld_addr `SB_WORD_SLICE(AW)),
      .o_hit      (w_hit),
      .o_hit_data (w_hit_data)
   );

   assign ld_data    = (ld_en && w_hit) ? w_hit_data : mem_rdata;
   assign mem_raddr  = ld_addr;
   assign mem_wvalid = (r_count != '0);
   assign mem_waddr  = {r_ent[r_head][EW-1:DW], 2'b00};
   assign mem_wdata  = r_ent[r_head][DW-1:0];
   assign full       = w_full;
   assign empty      = (r_count == '0);
   assign overflow   = r_overflow;

   assign w_unused_st_lsbs = ^st_addr[1:0];

endmodule

// File: tb/tb_pipe_store_buffer.sv
// Self-checking bench for pipe_store_buffer: a queue-based model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pipe_store_buffer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [29:0] waddr;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clock;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        mem_wvalid;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_wready;
   logic        full;
   logic        empty;
   logic        overflow;

   int   checks   = 0;
   int   failures = 0;
   bit   cmp_en   = 0;

   ent_t mq[$];
   bit   m_ovf;
   wr_t  wlog[$];
   wr_t  exp_wr[$];

   pipe_store_buffer #(
      .DEPTH (DEPTH),
      .AW    (32),
      .DW    (32)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .st_valid   (st_valid),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .mem_wvalid (mem_wvalid),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wready (mem_wready),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_ld();
      if (!ld_en) return mem_rdata;
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].waddr == ld_addr[31:2]) return mq[i].data;
      return mem_rdata;
   endfunction

   // Behavioural model: a plain FIFO of stores plus a sticky overflow bit.
   always @(posedge clock) begin
      if (reset) begin
         mq.delete();
         m_ovf <= 1'b0;
      end else begin
         if (st_valid && mq.size() == DEPTH && !mem_wready) m_ovf <= 1'b1;
         if (mq.size() != 0 && mem_wready) void'(mq.pop_front());
         if (st_valid && mq.size() < DEPTH) mq.push_back('{st_addr[31:2], st_data});
      end
   end

   // Memory side: record every write the DUT hands over.
   always @(posedge clock) begin
      if (!reset && mem_wvalid && mem_wready) wlog.push_back('{mem_waddr, mem_wdata});
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         check("mem_wvalid", mem_wvalid, mq.size() != 0);
         check("full", full, mq.size() == DEPTH);
         check("empty", empty, mq.size() == 0);
         check("overflow", overflow, m_ovf);
         check("mem_raddr", mem_raddr, ld_addr);
         check("ld_data", ld_data, exp_ld());
         if (mq.size() != 0) begin
            check("mem_waddr", mem_waddr, {mq[0].waddr, 2'b00});
            check("mem_wdata", mem_wdata, mq[0].data);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic check_log(input string name);
      check({name, "_count"}, wlog.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wlog.size(); i++) begin
         check({name, "_addr"}, wlog[i].addr, exp_wr[i].addr);
         check({name, "_data"}, wlog[i].data, exp_wr[i].data);
      end
   endtask

   initial begin
      reset      = 1'b1;
      st_valid   = 1'b0;
      st_addr    = '0;
      st_data    = '0;
      ld_en      = 1'b0;
      ld_addr    = '0;
      mem_rdata  = 32'h0;
      mem_wready = 1'b0;
      tick();
      tick();
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Reset / idle state and a plain load from memory.
      tick();
      check("t1_empty", empty, 1'b1);
      check("t1_full", full, 1'b0);
      check("t1_wvalid", mem_wvalid, 1'b0);
      check("t1_ovf", overflow, 1'b0);
      ld_en = 1'b1; ld_addr = 32'h10; mem_rdata = 32'hAAAA;
      #1;
      check("t1_ld", ld_data, 32'hAAAA);
      check("t1_raddr", mem_raddr, 32'h10);
      tick();
      ld_en = 1'b0;

      // Single store held by a 3-cycle stall, then accepted.
      wlog.delete();
      store(32'h10, 32'h1234);
      for (int c = 0; c < 3; c++) begin
         check("t2_wvalid", mem_wvalid, 1'b1);
         check("t2_waddr", mem_waddr, 32'h10);
         check("t2_wdata", mem_wdata, 32'h1234);
         tick();
      end
      mem_wready = 1'b1;
      tick();
      mem_wready = 1'b0;
      check("t2_empty", empty, 1'b1);
      exp_wr.delete();
      exp_wr.push_back('{32'h10, 32'h1234});
      check_log("t2_log");

      // Forwarding: youngest of two same-word stores wins.
      wlog.delete();
      store(32'h20, 32'h1);
      store(32'h24, 32'h2);
      store(32'h22, 32'h3);
      ld_en = 1'b1; mem_rdata = 32'hBEEF;
      ld_addr = 32'h20; #1;
      check("t3_ld20", ld_data, 32'h3);
      ld_addr = 32'h24; #1;
      check("t3_ld24", ld_data, 32'h2);
      ld_addr = 32'h28; #1;
      check("t3_ld28", ld_data, 32'hBEEF);
      ld_addr = 32'h20; ld_en = 1'b0; #1;
      check("t3_ld_off", ld_data, 32'hBEEF);
      mem_wready = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      mem_wready = 1'b0;
      exp_wr.delete();
      exp_wr.push_back('{32'h20, 32'h1});
      exp_wr.push_back('{32'h24, 32'h2});
      exp_wr.push_back('{32'h20, 32'h3});
      check_log("t3_log");

      // Fill, overflow on a 5th store, then drain in order.
      wlog.delete();
      exp_wr.delete();
      for (int k = 0; k < DEPTH; k++) begin
         store(32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
         exp_wr.push_back('{32'h100 + 32'(4 * k), 32'hA0 + 32'(k)});
      end
      check("t4_full", full, 1'b1);
      check("t4_ovf0", overflow, 1'b0);
      store(32'h110, 32'hFF);
      check("t4_ovf1", overflow, 1'b1);
      check("t4_full_after", full, 1'b1);
      mem_wready = 1'b1;
      for (int c = 0; c < DEPTH + 2; c++) tick();
      mem_wready = 1'b0;
      check("t4_empty", empty, 1'b1);
      check("t4_ovf_sticky", overflow, 1'b1);
      check_log("t4_log");
      do_reset();
      check("t4_ovf_cleared", overflow, 1'b0);

      // Full buffer with simultaneous enqueue and dequeue over 10 cycles.
      wlog.delete();
      exp_wr.delete();
      for (int k = 0; k < DEPTH; k++) begin
         store(32'h300 + 32'(4 * k), 32'hC0 + 32'(k));
         exp_wr.push_back('{32'h300 + 32'(4 * k), 32'hC0 + 32'(k)});
      end
      mem_wready = 1'b1;
      st_valid   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         st_addr = 32'h200 + 32'(4 * k);
         st_data = 32'hB0 + 32'(k);
         exp_wr.push_back('{st_addr, st_data});
         tick();
         check("t5_full", full, 1'b1);
         check("t5_ovf", overflow, 1'b0);
      end
      st_valid = 1'b0;
      for (int c = 0; c < DEPTH + 1; c++) tick();
      mem_wready = 1'b0;
      check("t5_empty", empty, 1'b1);
      check_log("t5_log");

      // Reset with pending stores discards them.
      store(32'h40, 32'h11);
      store(32'h44, 32'h22);
      store(32'h48, 32'h33);
      check("t6_pending", mem_wvalid, 1'b1);
      do_reset();
      check("t6_empty", empty, 1'b1);
      check("t6_wvalid", mem_wvalid, 1'b0);
      wlog.delete();
      exp_wr.delete();
      mem_wready = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      mem_wready = 1'b0;
      check_log("t6_log");

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
